noc_mem_pkt_gate: RTL and testbench

NOC_MEM_PKT_GATE -- requirements
Module: noc_mem_pkt_gate

---
 rtl/noc_mem_pkt_gate.sv | 144 ++++++++++++++
 tb/tb_noc_mem_pkt_gate.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_mem_pkt_gate.sv
// Packet gate in front of the memory bridge: buffers NoC2 flits in a small
// FIFO and releases a new packet only once memory calibration is complete.
// A packet already started is always finished, even if calibration drops.
// Flit width comes from NOC_DATA_WIDTH (default 64).
// Optional statistics counters are enabled with NOC_PKT_GATE_STATS_EN.

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

module noc_mem_pkt_gate #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned LEN_LO = 22,
  localparam int unsigned W     = `NOC_DATA_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         phy_init_done,
  input  logic         in_val,
  input  logic [W-1:0] in_dat,
  output logic         in_rdy,
  output logic         out_val,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy,
  output logic         busy,
  output logic [15:0]  pkt_cnt,
  output logic [15:0]  blocked_cycles
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [0:0] {StIdle, StBody} state_e;

  state_e        state_q, state_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]    remain_q, remain_d;
  logic          ready_q;
  logic [W-1:0]  mem_q [DEPTH];

  logic          full, empty, push, pop;
  logic [7:0]    head_len;

  // Extra pointer bit separates full from empty when the indices match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // ready_q keeps in_rdy low during reset and rises on the first clock after.
  assign in_rdy   = ready_q & ~full;
  assign out_val  = ~empty & ((state_q == StBody) | phy_init_done);
  assign out_dat  = mem_q[rd_ptr_q[AW-1:0]];
  assign head_len = out_dat[LEN_LO +: 8];
  assign push     = in_val & in_rdy;
  assign pop      = out_val & out_rdy;
  assign busy     = (state_q == StBody);

  // Next-state for pointers and the packet tracking FSM.
  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    wr_ptr_d = wr_ptr_q + (AW+1)'(push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    if (pop) begin
      unique case (state_q)
        StIdle: begin
          if (head_len != 8'd0) begin
            remain_d = head_len;
            state_d  = StBody;
          end
        end
        StBody: begin
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      remain_q <= 8'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= 1'b1;
    end
  end

  // Flit storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_dat;
    end
  end

`ifdef NOC_PKT_GATE_STATS_EN
  logic        pkt_done;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] blocked_q, blocked_d;

  assign pkt_done = pop && (((state_q == StIdle) && (head_len == 8'd0)) ||
                            ((state_q == StBody) && (remain_q == 8'd1)));

  // Packet counter wraps; blocked counter saturates.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    blocked_d = blocked_q;
    if (pkt_done) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
    if ((state_q == StIdle) && !empty && !phy_init_done && (blocked_q != 16'hFFFF)) begin
      blocked_d = blocked_q + 16'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q <= 16'd0;
      blocked_q <= 16'd0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      blocked_q <= blocked_d;
    end
  end

  assign pkt_cnt        = pkt_cnt_q;
  assign blocked_cycles = blocked_q;
`else
  assign pkt_cnt        = 16'd0;
  assign blocked_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_noc_mem_pkt_gate.sv
// Self-checking bench for noc_mem_pkt_gate: a queue-based packet model
// checked against the DUT every cycle, plus directed scenarios with
// hand-computed expectations and a randomized phase.

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

module tb_noc_mem_pkt_gate;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned LEN_LO = 22;
  localparam int unsigned W      = `NOC_DATA_WIDTH;
`ifdef NOC_PKT_GATE_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic         clk;
  logic         rst_n;
  logic         phy_init_done;
  logic         in_val;
  logic [W-1:0] in_dat;
  logic         in_rdy;
  logic         out_val;
  logic [W-1:0] out_dat;
  logic         out_rdy;
  logic         busy;
  logic [15:0]  pkt_cnt;
  logic [15:0]  blocked_cycles;

  noc_mem_pkt_gate #(
    .DEPTH (DEPTH),
    .LEN_LO(LEN_LO)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .phy_init_done (phy_init_done),
    .in_val        (in_val),
    .in_dat        (in_dat),
    .in_rdy        (in_rdy),
    .out_val       (out_val),
    .out_dat       (out_dat),
    .out_rdy       (out_rdy),
    .busy          (busy),
    .pkt_cnt       (pkt_cnt),
    .blocked_cycles(blocked_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: flits in order, whether a packet body is in progress, how many
  // payload flits it still owes, and the statistics.
  logic [W-1:0] q[$];
  bit           m_rdy_en;
  bit           m_in_pkt;
  int           m_left;
  logic [15:0]  m_pkt;
  logic [15:0]  m_blk;
  bit           m_pushed;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mk(input int len);
    logic [W-1:0] d;
    d = W'({$urandom, $urandom});
    d[LEN_LO +: 8] = 8'(len);
    return d;
  endfunction

  task automatic compare();
    bit exp_val;
    if (!rst_n) begin
      chk("rst_in_rdy", W'(in_rdy), '0);
      chk("rst_out_val", W'(out_val), '0);
      chk("rst_busy", W'(busy), '0);
      chk("rst_pkt_cnt", W'(pkt_cnt), '0);
      chk("rst_blocked", W'(blocked_cycles), '0);
    end else begin
      exp_val = (q.size() > 0) && (m_in_pkt || phy_init_done);
      chk("in_rdy", W'(in_rdy), W'(m_rdy_en && (q.size() < DEPTH)));
      chk("out_val", W'(out_val), W'(exp_val));
      if (exp_val) chk("out_dat", out_dat, q[0]);
      chk("busy", W'(busy), W'(m_in_pkt));
      chk("pkt_cnt", W'(pkt_cnt), STATS ? W'(m_pkt) : '0);
      chk("blocked", W'(blocked_cycles), STATS ? W'(m_blk) : '0);
    end
  endtask

  task automatic update();
    bit push, pop;
    logic [W-1:0] f;
    m_pushed = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_rdy_en = 1'b0;
      m_in_pkt = 1'b0;
      m_left   = 0;
      m_pkt    = '0;
      m_blk    = '0;
    end else begin
      push = in_val && m_rdy_en && (q.size() < DEPTH);
      pop  = out_rdy && (q.size() > 0) && (m_in_pkt || phy_init_done);
      if (!m_in_pkt && (q.size() > 0) && !phy_init_done && (m_blk != 16'hFFFF)) m_blk++;
      if (pop) begin
        f = q.pop_front();
        if (!m_in_pkt) begin
          m_left = int'(f[LEN_LO +: 8]);
          if (m_left == 0) m_pkt++;
          else m_in_pkt = 1'b1;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_in_pkt = 1'b0;
            m_pkt++;
          end
        end
      end
      if (push) q.push_back(in_dat);
      m_pushed = push;
      m_rdy_en = 1'b1;
    end
  endtask

  // One cycle: compare mid-cycle, advance the model on the edge, then
  // return just after the edge where stimulus may change.
  task automatic cyc();
    @(negedge clk);
    compare();
    @(posedge clk);
    update();
    #1;
  endtask

  task automatic wait_empty(input int budget, input string name);
    int n = 0;
    while ((q.size() > 0) && (n < budget)) begin
      cyc();
      n++;
    end
    chk(name, W'(q.size()), '0);
  endtask

  task automatic push_one(input logic [W-1:0] d);
    in_val = 1'b1;
    in_dat = d;
    cyc();
    in_val = 1'b0;
  endtask

  logic [W-1:0] hdr;

  initial begin
    rst_n = 1'b0; phy_init_done = 1'b0; in_val = 1'b0; in_dat = '0; out_rdy = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc(); cyc();

    // Gate closed: header L=2 plus two payloads wait in the buffer.
    hdr = mk(2);
    push_one(hdr);
    push_one(mk(7));
    push_one(mk(1));
    repeat (5) cyc();
    chk("gate_closed_out_val", W'(out_val), '0);
    chk("gate_closed_in_rdy", W'(in_rdy), W'(1));
    chk("gate_closed_blocked", W'(blocked_cycles), W'(7 * STATS));
    phy_init_done = 1'b1; out_rdy = 1'b1;
    #1;
    chk("gate_open_out_val", W'(out_val), W'(1));
    chk("gate_open_head", out_dat, hdr);
    repeat (3) cyc();
    chk("pkt1_cnt", W'(pkt_cnt), W'(STATS));
    chk("pkt1_drained", W'(out_val), '0);

    // Zero-length header: visible the cycle after push, never enters body.
    out_rdy = 1'b0;
    hdr = mk(0);
    push_one(hdr);
    chk("l0_out_val", W'(out_val), W'(1));
    chk("l0_out_dat", out_dat, hdr);
    out_rdy = 1'b1;
    cyc();
    chk("l0_busy", W'(busy), '0);
    chk("l0_pkt_cnt", W'(pkt_cnt), W'(2 * STATS));

    // Back-pressure: nine flits into an eight-entry buffer.
    out_rdy = 1'b0;
    for (int i = 0; i < 8; i++) push_one(i == 0 ? mk(8) : mk(5));
    chk("full_in_rdy", W'(in_rdy), '0);
    in_val = 1'b1; in_dat = mk(3);
    repeat (3) cyc();
    chk("full_held", W'(q.size()), W'(DEPTH));
    out_rdy = 1'b1;
    for (int n = 0; n < 20 && !m_pushed; n++) cyc();
    chk("ninth_accepted", W'(m_pushed), W'(1));
    in_val = 1'b0;
    wait_empty(40, "full_drain");
    chk("full_pkt_cnt", W'(pkt_cnt), W'(3 * STATS));

    // Gate drops mid-packet: body finishes, next header is held.
    out_rdy = 1'b0;
    push_one(mk(3));
    for (int i = 0; i < 3; i++) push_one(mk(0));
    hdr = mk(0);
    push_one(hdr);
    out_rdy = 1'b1;
    cyc();
    phy_init_done = 1'b0;
    repeat (6) cyc();
    chk("drop_out_val", W'(out_val), '0);
    chk("drop_busy", W'(busy), '0);
    chk("drop_held_hdr", (q.size() == 1) ? q[0] : '0, hdr);
    chk("drop_pkt_cnt", W'(pkt_cnt), W'(4 * STATS));
    phy_init_done = 1'b1;
    wait_empty(10, "drop_drain");
    chk("drop_pkt_cnt2", W'(pkt_cnt), W'(5 * STATS));

    // Reset while in BODY with two flits buffered.
    out_rdy = 1'b0;
    push_one(mk(4));
    push_one(mk(0));
    push_one(mk(0));
    out_rdy = 1'b1;
    cyc();
    out_rdy = 1'b0;
    chk("pre_rst_busy", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_now_out_val", W'(out_val), '0);
    chk("rst_now_busy", W'(busy), '0);
    chk("rst_now_pkt_cnt", W'(pkt_cnt), '0);
    chk("rst_now_blocked", W'(blocked_cycles), '0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    hdr = mk(0);
    out_rdy = 1'b1;
    push_one(hdr);
    chk("post_rst_out_val", W'(out_val), W'(1));
    chk("post_rst_hdr", out_dat, hdr);
    cyc();
    chk("post_rst_pkt_cnt", W'(pkt_cnt), W'(STATS));

    // Randomized traffic with one reset in the middle.
    for (int n = 0; n < 1500; n++) begin
      in_val  = ($urandom_range(0, 2) != 0);
      in_dat  = mk(int'($urandom_range(0, 3)));
      out_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) phy_init_done = ~phy_init_done;
      if (n == 700) rst_n = 1'b0;
      if (n == 703) rst_n = 1'b1;
      cyc();
    end
    in_val = 1'b0; out_rdy = 1'b1; phy_init_done = 1'b1;
    wait_empty(100, "rand_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
